// File: rtl/write_ptr_ctrl.sv
// Write-side pointer controller for an asynchronous FIFO.
// Keeps the binary and Gray write pointers and produces full, almost-full
// and free-count flags against a read pointer already synchronized into
// write_clk.
// Optional feature: define WRITE_OVERFLOW_FLAG_EN to add a sticky overflow
// flag (write_overflow) with its clear input (write_overflow_clr).
//
// Handshake: write_incr is the request. write_accept = write_incr & ~write_full
// is the RAM write enable. The pointer advances on exactly those edges where
// write_accept is 1. A request made while full is dropped, not stalled.
module write_ptr_ctrl #(
  parameter int address_size       = 4,
  parameter int almost_full_margin = 2
) (
  input  logic                    write_clk,
  input  logic                    wreset_n,
  input  logic                    write_incr,
  input  logic [address_size:0]   read_pointer_gray_s,
  output logic [address_size:0]   write_pointer_gray,
  output logic [address_size:0]   write_pointer,
  output logic [address_size-1:0] write_address,
  output logic                    write_full,
  output logic                    write_almost_full,
  output logic [address_size:0]   write_free_count,
  output logic                    write_accept
`ifdef WRITE_OVERFLOW_FLAG_EN
  ,
  input  logic                    write_overflow_clr,
  output logic                    write_overflow
`endif
);

  localparam logic [address_size:0] depth_v  = {1'b1, {address_size{1'b0}}};
  localparam logic [address_size:0] margin_v = (address_size + 1)'(almost_full_margin);

  logic [address_size:0] rbin;
  logic [address_size:0] bin_next;
  logic [address_size:0] gray_next;
  logic [address_size:0] rgray_full;
  logic [address_size:0] free_next;
  logic                  full_next;
  logic                  almost_next;

  assign write_accept  = write_incr & ~write_full;
  assign write_address = write_pointer[address_size-1:0];

  // Gray-to-binary of the synchronized read pointer: MSB copied, XOR cascade down.
  always_comb begin
    rbin               = '0;
    rbin[address_size] = read_pointer_gray_s[address_size];
    for (int i = address_size - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ read_pointer_gray_s[i];
    end
  end

  // Next pointer values and the flags they imply, all from the post-write pointer.
  always_comb begin
    bin_next    = write_pointer + {{address_size{1'b0}}, write_accept};
    gray_next   = (bin_next >> 1) ^ bin_next;
    // Full when the write pointer is one lap ahead: in Gray this is the read
    // pointer with its top two bits inverted.
    rgray_full  = {~read_pointer_gray_s[address_size:address_size-1],
                   read_pointer_gray_s[address_size-2:0]};
    full_next   = (gray_next == rgray_full);
    // Occupancy uses modulo-2^(address_size+1) subtraction, so wrap is free.
    free_next   = depth_v - (bin_next - rbin);
    almost_next = (free_next <= margin_v);
  end

  // Pointer and flag registers.
  always_ff @(posedge write_clk or negedge wreset_n) begin
    if (!wreset_n) begin
      write_pointer      <= '0;
      write_pointer_gray <= '0;
      write_full         <= 1'b0;
      write_almost_full  <= 1'b0;
      write_free_count   <= depth_v;
    end else begin
      write_pointer      <= bin_next;
      write_pointer_gray <= gray_next;
      write_full         <= full_next;
      write_almost_full  <= almost_next;
      write_free_count   <= free_next;
    end
  end

`ifdef WRITE_OVERFLOW_FLAG_EN
  // Sticky overflow: a dropped request sets it; set wins over clear.
  always_ff @(posedge write_clk or negedge wreset_n) begin
    if (!wreset_n) begin
      write_overflow <= 1'b0;
    end else if (write_incr & write_full) begin
      write_overflow <= 1'b1;
    end else if (write_overflow_clr) begin
      write_overflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_write_ptr_ctrl.sv
// Directed bench for write_ptr_ctrl (address_size=4, almost_full_margin=2).
// Inputs are driven and outputs sampled on the falling edge of write_clk.
module tb_write_ptr_ctrl;

  localparam int AW = 4;

  // ---------------- clock / reset ----------------
  logic          write_clk = 1'b0;
  logic          wreset_n  = 1'b0;
  logic          write_incr = 1'b0;
  logic [AW:0]   read_pointer_gray_s = '0;
  logic [AW:0]   write_pointer_gray;
  logic [AW:0]   write_pointer;
  logic [AW-1:0] write_address;
  logic          write_full;
  logic          write_almost_full;
  logic [AW:0]   write_free_count;
  logic          write_accept;
  logic          write_overflow_clr = 1'b0;
`ifdef WRITE_OVERFLOW_FLAG_EN
  logic          write_overflow;
`endif

  always #5 write_clk = ~write_clk;

  write_ptr_ctrl #(.address_size(AW), .almost_full_margin(2)) dut (
    .write_clk           (write_clk),
    .wreset_n            (wreset_n),
    .write_incr          (write_incr),
    .read_pointer_gray_s (read_pointer_gray_s),
    .write_pointer_gray  (write_pointer_gray),
    .write_pointer       (write_pointer),
    .write_address       (write_address),
    .write_full          (write_full),
    .write_almost_full   (write_almost_full),
    .write_free_count    (write_free_count),
    .write_accept        (write_accept)
`ifdef WRITE_OVERFLOW_FLAG_EN
    ,
    .write_overflow_clr  (write_overflow_clr),
    .write_overflow      (write_overflow)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock: through the rising edge, back to the falling edge.
  task automatic tick();
    @(posedge write_clk);
    @(negedge write_clk);
  endtask

  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_state(input string tag, input logic [AW:0] ptr, input logic [AW:0] free,
                             input logic full, input logic af);
    check_val({tag, "_ptr"},   32'(write_pointer), 32'(ptr));
    check_val({tag, "_gray"},  32'(write_pointer_gray), 32'(to_gray(ptr)));
    check_val({tag, "_addr"},  32'(write_address), 32'(ptr[AW-1:0]));
    check_val({tag, "_free"},  32'(write_free_count), 32'(free));
    check_val({tag, "_full"},  32'(write_full), 32'(full));
    check_val({tag, "_afull"}, 32'(write_almost_full), 32'(af));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset and idle ----
    @(negedge write_clk);
    #1;
    check_state("in_reset", 5'd0, 5'd16, 1'b0, 1'b0);
    wreset_n = 1'b1;
    tick();
    tick();
    check_state("idle", 5'd0, 5'd16, 1'b0, 1'b0);
    check_val("idle_gray_lit", 32'(write_pointer_gray), 32'd0);

    // ---- fill with 16 writes, read pointer at 0 ----
    for (int k = 1; k <= 16; k++) exp_q.push_back(32'(16 - k));
    for (int k = 1; k <= 16; k++) begin
      write_incr = 1'b1;
      #1;
      check_val("fill_accept", 32'(write_accept), 32'd1);
      tick();
      check_val("fill_free", 32'(write_free_count), exp_q.pop_front());
      check_val("fill_afull", 32'(write_almost_full), (k >= 14) ? 32'd1 : 32'd0);
      check_val("fill_full", 32'(write_full), (k == 16) ? 32'd1 : 32'd0);
    end
    check_val("full_ptr", 32'(write_pointer), 32'b10000);
    check_val("full_gray", 32'(write_pointer_gray), 32'b11000);
    // 17th request is refused
    #1;
    check_val("ovf_accept", 32'(write_accept), 32'd0);
    tick();
    check_state("ovf_hold", 5'd16, 5'd0, 1'b1, 1'b1);

`ifdef WRITE_OVERFLOW_FLAG_EN
    check_val("ovf_set", 32'(write_overflow), 32'd1);
    write_incr = 1'b0;
    write_overflow_clr = 1'b1;
    tick();
    check_val("ovf_clr", 32'(write_overflow), 32'd0);
    write_incr = 1'b1;
    tick();
    check_val("ovf_set_wins", 32'(write_overflow), 32'd1);
    write_overflow_clr = 1'b0;
    check_val("ovf_ptr_hold", 32'(write_pointer), 32'd16);
`endif

    // ---- read pointer advances by one while full ----
    write_incr = 1'b0;
    read_pointer_gray_s = 5'b00001;
    tick();
    check_state("one_free", 5'd16, 5'd1, 1'b0, 1'b1);

    // ---- 40 cycles of simultaneous write and read: free stays at 1 ----
    begin
      logic [AW:0] rp;
      logic [AW:0] wp;
      rp = 5'd1;
      wp = 5'd16;
      for (int c = 0; c < 40; c++) begin
        write_incr = 1'b1;
        rp = rp + 5'd1;
        wp = wp + 5'd1;
        read_pointer_gray_s = to_gray(rp);
        tick();
        check_val("stream_free", 32'(write_free_count), 32'd1);
        check_val("stream_full", 32'(write_full), 32'd0);
        check_val("stream_ptr", 32'(write_pointer), 32'(wp));
      end
      check_val("stream_wrap_ptr", 32'(write_pointer), 32'd24);
    end

    // ---- reset mid-burst at count 9 ----
    write_incr = 1'b0;
    wreset_n = 1'b0;
    #1;
    read_pointer_gray_s = '0;
    wreset_n = 1'b1;
    tick();
    check_state("re_empty", 5'd0, 5'd16, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      write_incr = 1'b1;
      tick();
    end
    check_state("burst9", 5'd9, 5'd7, 1'b0, 1'b0);
    // write_incr still high: pull reset mid-cycle, no clock edge in between
    #2;
    wreset_n = 1'b0;
    #1;
    check_state("async_rst", 5'd0, 5'd16, 1'b0, 1'b0);
    @(negedge write_clk);
    wreset_n = 1'b1;
    tick();
    check_state("after_rst", 5'd1, 5'd15, 1'b0, 1'b0);
    write_incr = 1'b0;

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
